udp_arbitr_n: RTL
=================

# udp_arbitr_n

Parametrised N-channel packet arbiter between the frame sources (ARP/ICMP, UDP streams) and the single MAC TX Avalon-ST port. It grants the MAC to one requesting source at a time and forwards that source's stream with one registered cycle of latency. It holds each grant for a whole packet (release on accepted EOP) and uses round-robin or fixed-priority selection. A per-grant inactivity timeout reclaims the port from a stalled source.

## Interface
Parameters:
- N_CH, 3, number of source channels (2..8); channel 0 is highest priority in fixed mode
- DATA_W, 32, data width
- MOD_W, 2, empty-bytes (mod) width
- RR, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- TIMEOUT, 4096, consecutive idle (wren=0) cycles while granted before forced release; 0 disables

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_rdy  in  1  ready from MAC
- en  in  N_CH  per-channel request (level)
- in_wren  in  N_CH  per-channel write enable
- in_sop  in  N_CH  per-channel start of packet
- in_eop  in  N_CH  per-channel end of packet
- in_mod  in  N_CH*MOD_W  per-channel mod; channel i at [i*MOD_W +: MOD_W]
- in_data  in  N_CH*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W]
- in_rdy  out  N_CH  per-channel ready (registered copy of tx_rdy for granted channel only)
- tx_wren, tx_sop, tx_eop  out  1  to MAC
- tx_mod  out  MOD_W  to MAC
- tx_data  out  DATA_W  to MAC
- grant  out  N_CH  one-hot current grant, 0 when none
- err_timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT (granted, waiting for first wren), XFER (packet in flight), GAP (one-cycle turnaround).
- IDLE: if en != 0, select a winner and enter GRANT; grant becomes one-hot at the next edge. Requests are sampled only in IDLE.
- Selection: RR=1 searches from index (last+1) mod N_CH upward and wraps; last = most recently granted channel, reset value N_CH-1, so channel 0 wins first. RR=0 always picks the lowest set index.
- GRANT: first cycle with in_wren[g]=1 moves to XFER, with or without sop. An in_wren[g]&in_eop[g] on that same cycle (single-beat packet) goes directly to GAP.
- XFER: in_wren[g]&in_eop[g] moves to GAP. Deassertion of wren alone does not release.
- GAP: all outputs forwarded as 0, grant cleared, last <= g; return to IDLE.
- Forwarding: in GRANT/XFER, tx_* <= in_*[g] every cycle, in_rdy[g] <= tx_rdy, all other in_rdy = 0. In IDLE/GAP, all tx_* and in_rdy are driven 0.
- Timeout (TIMEOUT>0): counter resets on any in_wren[g]=1 and counts while in GRANT/XFER with in_wren[g]=0. Reaching TIMEOUT pulses err_timeout and goes to GAP. No synthetic EOP is inserted. Counter width is clog2(TIMEOUT+1).
- en[g] deasserting mid-grant has no effect; release happens only via EOP or timeout.
- Reset: state IDLE, grant=0, last=N_CH-1, counter=0, all outputs 0. Reset mid-packet truncates the packet at the next edge.

## Timing
- Request to grant: en asserted at cycle t in IDLE gives grant valid at t+1; in_rdy[g] reflects tx_rdy from t+2.
- Data latency: in_*[g] at cycle k appears on tx_* at k+1, while state is GRANT/XFER at k.
- EOP beat at cycle k is forwarded at k+1. GAP occupies k+1, so the earliest next grant is at k+3. Minimum inter-packet gap on tx_wren is 2 cycles.
- Timeout: last wren at cycle k gives err_timeout high at k+TIMEOUT+1 for exactly one cycle. Grant is 0 from the following cycle.
- Simultaneous en on several channels: exactly one grant, never more than one bit set.

## Test plan
- Single source: en[1]=1, 4-beat packet (sop beat 0, eop beat 3, mod=2, data 0xA0..0xA3) -> tx_* identical one cycle later, grant=3'b010, released after eop; tx_wren low for 2 cycles minimum.
- Round-robin: en=3'b111 held, each channel sends a 2-beat packet -> grant order 0,1,2,0; no beat interleaving.
- Fixed priority (RR=0): en=3'b110 then en[0] rises mid-packet of ch1 -> ch1 completes, then ch0 granted before ch2.
- Timeout (TIMEOUT=16): ch2 granted, sends sop beat then stalls -> err_timeout pulse 17 cycles after last wren, grant=0, then ch0 request served.
- Ready gating: tx_rdy toggled during ch1 packet -> in_rdy[1] follows one cycle later, in_rdy[0]=in_rdy[2]=0 throughout.
- Reset mid-packet: rst=1 during beat 2 -> next cycle all tx_*=0, grant=0; after release, en=3'b101 grants channel 0 first.

Source files
------------

// File: rtl/udp_arbitr_n.sv
// udp_arbitr_n: N-channel packet arbiter onto one MAC TX stream with grant timeout
module udp_arbitr_n #(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 32,
  parameter int MOD_W   = 2,
  parameter int RR      = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_rdy,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH-1:0]          in_wren,
  input  logic [N_CH-1:0]          in_sop,
  input  logic [N_CH-1:0]          in_eop,
  input  logic [N_CH*MOD_W-1:0]    in_mod,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_rdy,
  output logic                     tx_wren,
  output logic                     tx_sop,
  output logic                     tx_eop,
  output logic [MOD_W-1:0]         tx_mod,
  output logic [DATA_W-1:0]        tx_data,
  output logic [N_CH-1:0]          grant,
  output logic                     err_timeout
);
  localparam int GW = $clog2(N_CH);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;
  state_t st_q, st_d;
  logic [GW-1:0] g_q, g_d, last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0] grant_q, grant_d, rdy_q, rdy_d;
  logic wren_q, wren_d, sop_q, sop_d, eop_q, eop_d, to_q, to_d;
  logic [MOD_W-1:0] mod_q, mod_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic found, act, wr, to_hit;
  int idx;
  // Winner search: rotate from the channel after the last grant, or take the lowest index
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = RR != 0 ? (int'(last_q) + 1 + i) % N_CH : i;
      if (!found && en[idx]) begin
        win = GW'(idx);
        found = 1'b1;
      end
    end
  end
  // Next state, grant bookkeeping, idle counter and the beat to forward
  always_comb begin
    act = st_q == GRANT || st_q == XFER;
    wr = act && in_wren[g_q];
    to_hit = TIMEOUT > 0 && act && !wr && cnt_q == CW'(TIMEOUT - 1);
    st_d = st_q;
    g_d = g_q;
    last_d = last_q;
    grant_d = grant_q;
    cnt_d = (TIMEOUT > 0 && act && !wr) ? cnt_q + 1'b1 : '0;
    to_d = to_hit;
    if (st_q == IDLE && found) begin
      st_d = GRANT;
      g_d = win;
      grant_d = N_CH'(1) << win;
    end
    if (wr) st_d = in_eop[g_q] ? GAP : XFER;
    if (to_hit) st_d = GAP;
    if (st_q == GAP) begin
      st_d = IDLE;
      grant_d = '0;
      last_d = g_q;
    end
    wren_d = wr;
    sop_d = act && in_sop[g_q];
    eop_d = act && in_eop[g_q];
    mod_d = act ? in_mod[g_q*MOD_W +: MOD_W] : '0;
    data_d = act ? in_data[g_q*DATA_W +: DATA_W] : '0;
    rdy_d = act ? N_CH'(tx_rdy) << g_q : '0;
  end
  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      g_q <= '0;
      last_q <= GW'(N_CH - 1);
      cnt_q <= '0;
      grant_q <= '0;
      rdy_q <= '0;
      wren_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      to_q <= 1'b0;
      mod_q <= '0;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      g_q <= g_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      rdy_q <= rdy_d;
      wren_q <= wren_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      to_q <= to_d;
      mod_q <= mod_d;
      data_q <= data_d;
    end
  end
  assign grant = grant_q;
  assign in_rdy = rdy_q;
  assign tx_wren = wren_q;
  assign tx_sop = sop_q;
  assign tx_eop = eop_q;
  assign tx_mod = mod_q;
  assign tx_data = data_q;
  assign err_timeout = to_q;
endmodule
